plot_sequencer: RTL

- Top-level controller for one plot pass.
- On start, pulses the expression parser and waits for it to finish filling the RPN output queue.
- Then sweeps every screen column: drives x into the RPN evaluator, maps each result to a screen row, and writes one pixel per column to the framebuffer writer.
- Sits between the user-input/control logic and the parser, evaluator and framebuffer datapaths.

---
 rtl/plot_pkg.sv | 37 +++
 rtl/plot_coord_map.sv | 57 +++++
 rtl/plot_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/plot_pkg.sv
// rtl/plot_pkg.sv - shared widths, screen geometry, state encoding and coordinate mapping
package plot_pkg;

    localparam int DEF_INTEGER_PART_WIDTH    = 8;
    localparam int DEF_FRACTIONAL_PART_WIDTH = 8;
    localparam int DEF_NUMBER_WIDTH          = DEF_INTEGER_PART_WIDTH + DEF_FRACTIONAL_PART_WIDTH;
    localparam int DEF_SCREEN_WIDTH          = 640;
    localparam int DEF_SCREEN_HEIGHT         = 480;
    localparam int DEF_X_ORIGIN              = 320;
    localparam int DEF_Y_ORIGIN              = 240;
    localparam int DEF_X_SCALE_LOG2          = 5;
    localparam int DEF_Y_SCALE_LOG2          = 5;
    localparam int DEF_PARSE_TIMEOUT         = 65535;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_PARSE_START = 4'd1,
        ST_PARSE_WAIT  = 4'd2,
        ST_EVAL_START  = 4'd3,
        ST_EVAL_WAIT   = 4'd4,
        ST_MAP         = 4'd5,
        ST_PIXEL_WRITE = 4'd6,
        ST_NEXT_COL    = 4'd7,
        ST_FINISH      = 4'd8
    } plot_state_t;

    // Column index to fixed-point x; caller truncates to the number width.
    function automatic int col_to_x(input int col, input int x_origin, input int shift);
        return (col - x_origin) <<< shift;
    endfunction

    // Fixed-point y (already sign-extended) to screen row; shift floors toward -inf.
    function automatic int result_to_row(input int result, input int y_origin, input int shift);
        return y_origin - (result >>> shift);
    endfunction

endpackage

// File: rtl/plot_coord_map.sv
// rtl/plot_coord_map.sv - column to x conversion and evaluator result to screen row mapping
module plot_coord_map import plot_pkg::*; #(
    parameter int NUMBER_WIDTH          = DEF_NUMBER_WIDTH,
    parameter int FRACTIONAL_PART_WIDTH = DEF_FRACTIONAL_PART_WIDTH,
    parameter int SCREEN_WIDTH          = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT         = DEF_SCREEN_HEIGHT,
    parameter int X_ORIGIN              = DEF_X_ORIGIN,
    parameter int Y_ORIGIN              = DEF_Y_ORIGIN,
    parameter int X_SCALE_LOG2          = DEF_X_SCALE_LOG2,
    parameter int Y_SCALE_LOG2          = DEF_Y_SCALE_LOG2,
    localparam int COL_W                = $clog2(SCREEN_WIDTH),
    localparam int ROW_W                = $clog2(SCREEN_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [COL_W-1:0]        i_col,
    input  logic                    i_capture,
    input  logic [NUMBER_WIDTH-1:0] i_result,
    input  logic                    i_result_err,
    output logic [NUMBER_WIDTH-1:0] o_x,
    output logic [ROW_W-1:0]        o_row,
    output logic                    o_row_ok
);

    // Row arithmetic carries two extra bits so Y_ORIGIN minus any shifted result cannot wrap.
    localparam int RW = NUMBER_WIDTH + 2;
    localparam logic signed [RW-1:0] HEIGHT_S = RW'(SCREEN_HEIGHT);

    logic signed [RW-1:0] w_row_wide;
    logic                 w_row_ok;
    logic [ROW_W-1:0]     r_row;
    logic                 r_row_ok;

    // Combinational x for the requested column and candidate row for the incoming result.
    always_comb begin
        o_x        = NUMBER_WIDTH'(col_to_x(int'(i_col), X_ORIGIN,
                                            FRACTIONAL_PART_WIDTH - X_SCALE_LOG2));
        w_row_wide = RW'(result_to_row(int'($signed(i_result)), Y_ORIGIN,
                                       FRACTIONAL_PART_WIDTH - Y_SCALE_LOG2));
        w_row_ok   = !i_result_err && !w_row_wide[RW-1] && (w_row_wide < HEIGHT_S);
    end

    // Capture the mapped row and its visibility when the evaluator answers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row    <= '0;
            r_row_ok <= 1'b0;
        end else if (i_capture) begin
            r_row    <= w_row_wide[ROW_W-1:0];
            r_row_ok <= w_row_ok;
        end
    end

    assign o_row    = r_row;
    assign o_row_ok = r_row_ok;

endmodule

// File: rtl/plot_sequencer.sv
// rtl/plot_sequencer.sv - plot pass controller: parse, then evaluate and draw one pixel per column
module plot_sequencer import plot_pkg::*; #(
    parameter int INTEGER_PART_WIDTH    = DEF_INTEGER_PART_WIDTH,
    parameter int FRACTIONAL_PART_WIDTH = DEF_FRACTIONAL_PART_WIDTH,
    parameter int SCREEN_WIDTH          = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT         = DEF_SCREEN_HEIGHT,
    parameter int X_ORIGIN              = DEF_X_ORIGIN,
    parameter int Y_ORIGIN              = DEF_Y_ORIGIN,
    parameter int X_SCALE_LOG2          = DEF_X_SCALE_LOG2,
    parameter int Y_SCALE_LOG2          = DEF_Y_SCALE_LOG2,
    parameter int PARSE_TIMEOUT         = DEF_PARSE_TIMEOUT,
    localparam int NUMBER_WIDTH         = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
    localparam int COL_W                = $clog2(SCREEN_WIDTH),
    localparam int ROW_W                = $clog2(SCREEN_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic                    parser_start,
    input  logic                    parser_ready,
    output logic                    eval_start,
    output logic [NUMBER_WIDTH-1:0] eval_x,
    input  logic                    eval_done,
    input  logic [NUMBER_WIDTH-1:0] eval_result,
    input  logic                    eval_error,
    output logic                    pixel_valid,
    output logic [COL_W-1:0]        pixel_x,
    output logic [ROW_W-1:0]        pixel_y,
    input  logic                    pixel_ready
);

    localparam int TMO_W = $clog2(PARSE_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PARSE_TIMEOUT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SCREEN_WIDTH - 1);

    plot_state_t             r_state;
    plot_state_t             w_state_next;
    logic [COL_W-1:0]        r_col;
    logic [COL_W-1:0]        w_col_next;
    logic [TMO_W-1:0]        r_tmo;
    logic                    r_error;
    logic [NUMBER_WIDTH-1:0] r_eval_x;
    logic [COL_W-1:0]        r_pixel_x;
    logic [ROW_W-1:0]        r_pixel_y;
    logic                    w_capture;
    logic                    w_timeout;
    logic [NUMBER_WIDTH-1:0] w_next_x;
    logic [ROW_W-1:0]        w_map_row;
    logic                    w_map_ok;

    // x is computed for the column about to be evaluated, so it is ready in EVAL_START.
    plot_coord_map #(
        .NUMBER_WIDTH          (NUMBER_WIDTH),
        .FRACTIONAL_PART_WIDTH (FRACTIONAL_PART_WIDTH),
        .SCREEN_WIDTH          (SCREEN_WIDTH),
        .SCREEN_HEIGHT         (SCREEN_HEIGHT),
        .X_ORIGIN              (X_ORIGIN),
        .Y_ORIGIN              (Y_ORIGIN),
        .X_SCALE_LOG2          (X_SCALE_LOG2),
        .Y_SCALE_LOG2          (Y_SCALE_LOG2)
    ) u_coord_map (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_col        (w_col_next),
        .i_capture    (w_capture),
        .i_result     (eval_result),
        .i_result_err (eval_error),
        .o_x          (w_next_x),
        .o_row        (w_map_row),
        .o_row_ok     (w_map_ok)
    );

    // Next-state, column advance and the single-cycle strobes decoded from the state.
    always_comb begin
        w_state_next = r_state;
        w_col_next   = r_col;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        parser_start = 1'b0;
        eval_start   = 1'b0;
        pixel_valid  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = ST_PARSE_START;
                    w_col_next   = '0;
                end
            end
            ST_PARSE_START: begin
                parser_start = 1'b1;
                w_state_next = ST_PARSE_WAIT;
            end
            ST_PARSE_WAIT: begin
                if (parser_ready) begin
                    w_state_next = ST_EVAL_START;
                end else if (r_tmo == TMO_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_FINISH;
                end
            end
            ST_EVAL_START: begin
                eval_start   = 1'b1;
                w_state_next = ST_EVAL_WAIT;
            end
            ST_EVAL_WAIT: begin
                if (eval_done) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_MAP;
                end
            end
            ST_MAP: begin
                w_state_next = w_map_ok ? ST_PIXEL_WRITE : ST_NEXT_COL;
            end
            ST_PIXEL_WRITE: begin
                pixel_valid = 1'b1;
                if (pixel_ready) begin
                    w_state_next = ST_NEXT_COL;
                end
            end
            ST_NEXT_COL: begin
                if (r_col == COL_LAST) begin
                    w_state_next = ST_FINISH;
                end else begin
                    w_col_next   = r_col + COL_W'(1);
                    w_state_next = ST_EVAL_START;
                end
            end
            ST_FINISH: begin
                busy         = 1'b0;
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register and current column.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
        end else begin
            r_state <= w_state_next;
            r_col   <= w_col_next;
        end
    end

    // Parser wait counter: cleared while pulsing the parser, counts each unready wait cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (r_state == ST_PARSE_START) begin
            r_tmo <= '0;
        end else if (r_state == ST_PARSE_WAIT) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    // Sticky timeout flag, cleared only when a new pass is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_error <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end
    end

    // eval_x loads on entry to EVAL_START and holds through the evaluator wait.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_eval_x <= '0;
        end else if (w_state_next == ST_EVAL_START) begin
            r_eval_x <= w_next_x;
        end
    end

    // Pixel coordinates load on entry to PIXEL_WRITE and hold until the handshake completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pixel_x <= '0;
            r_pixel_y <= '0;
        end else if (r_state == ST_MAP && w_map_ok) begin
            r_pixel_x <= r_col;
            r_pixel_y <= w_map_row;
        end
    end

    assign error   = r_error;
    assign eval_x  = r_eval_x;
    assign pixel_x = r_pixel_x;
    assign pixel_y = r_pixel_y;

endmodule
